// File: rtl/rv_ctrl_pkg.sv
// Shared control constants for the RV32I pipeline: branch funct3 codes,
// redirect FSM state encoding and the sequential PC step.
package rv_ctrl_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int unsigned PC_STEP = 4;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } redir_state_t;

endpackage

// File: rtl/branch_target_add.sv
// Control-flow target adder: base is rs1 for JALR, pc otherwise. JALR clears
// bit 0 of the sum. Flags targets that are not reachable without compressed
// instruction support.
module branch_target_add #(
  parameter int XLEN  = 32,
  parameter int HAS_C = 0
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] imm,
  input  logic            is_jalr,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);

  logic [XLEN-1:0] sum;

  // Base select, add (wraps modulo 2^XLEN) and JALR bit-0 clear.
  always_comb begin
    sum    = (is_jalr ? rs1 : pc) + imm;
    target = sum;
    if (is_jalr) target[0] = 1'b0;
  end

  // Bit 0 is always zero here, so only bit 1 matters, and only without C.
  assign misaligned = (HAS_C != 0) ? 1'b0 : target[1];

endmodule

// File: rtl/branch_redirect_ctrl.sv
// EX-stage branch/JAL/JALR resolution and PC-redirect sequencer. Holds both
// front-end flushes while fetch has not yet taken the new PC, and counts
// accepted redirects with a saturating counter.
//
// state       | meaning
// ST_IDLE     | resolving EX instructions, no redirect outstanding
// ST_REDIRECT | redirect_pc offered to fetch, front-end flushed, EX ignored
module branch_redirect_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16,
  parameter int HAS_C = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_is_jal,
  input  logic             ex_is_jalr,
  input  logic [2:0]       ex_funct3,
  input  logic             ex_cmp_eq,
  input  logic             ex_cmp_lt,
  input  logic             ex_cmp_ltu,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_rs1,
  input  logic [XLEN-1:0]  ex_imm,
  input  logic             fetch_ready,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic [XLEN-1:0]  link_pc,
  output logic             misalign_exc,
  output logic [CNT_W-1:0] redirect_cnt
);

  redir_state_t    state, state_next;
  logic            cond;
  logic            taken;
  logic [XLEN-1:0] target;
  logic            misaligned;
  logic            pc_load;
  logic            exc_next;
  logic            cnt_inc;

  branch_target_add #(
    .XLEN  (XLEN),
    .HAS_C (HAS_C)
  ) u_target (
    .pc         (ex_pc),
    .rs1        (ex_rs1),
    .imm        (ex_imm),
    .is_jalr    (ex_is_jalr),
    .target     (target),
    .misaligned (misaligned)
  );

  assign link_pc = ex_pc + XLEN'(PC_STEP);

  // Branch condition decode; unused funct3 codes never take.
  always_comb begin
    cond = 1'b0;
    case (ex_funct3)
      F3_BEQ:  cond = ex_cmp_eq;
      F3_BNE:  cond = ~ex_cmp_eq;
      F3_BLT:  cond = ex_cmp_lt;
      F3_BGE:  cond = ~ex_cmp_lt;
      F3_BLTU: cond = ex_cmp_ltu;
      F3_BGEU: cond = ~ex_cmp_ltu;
      default: cond = 1'b0;
    endcase
    taken = ex_valid & (ex_is_jal | ex_is_jalr | (ex_is_branch & cond));
  end

  // Next-state and registered-output decisions.
  always_comb begin
    state_next = state;
    pc_load    = 1'b0;
    exc_next   = 1'b0;
    cnt_inc    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (taken && !misaligned) begin
          state_next = ST_REDIRECT;
          pc_load    = 1'b1;
        end else if (taken) begin
          exc_next = 1'b1;
        end
      end
      ST_REDIRECT: begin
        if (fetch_ready) begin
          state_next = ST_IDLE;
          cnt_inc    = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State, registered outputs and saturating redirect counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      redirect_valid <= 1'b0;
      flush_if_id    <= 1'b0;
      flush_id_ex    <= 1'b0;
      misalign_exc   <= 1'b0;
      redirect_pc    <= '0;
      redirect_cnt   <= '0;
    end else begin
      state          <= state_next;
      redirect_valid <= (state_next == ST_REDIRECT);
      flush_if_id    <= (state_next == ST_REDIRECT);
      flush_id_ex    <= (state_next == ST_REDIRECT);
      misalign_exc   <= exc_next;
      if (pc_load) redirect_pc <= target;
      if (cnt_inc && (redirect_cnt != {CNT_W{1'b1}})) redirect_cnt <= redirect_cnt + 1'b1;
    end
  end

endmodule
